// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - multi-cycle shift sequencer over one 8-bit, 0..3-step shift stage
//
// Purpose: accepts one shift request (operand, op, total amount 0..7). It applies the
//          amount as repeated passes of at most 3 positions through a single small stage.
//          When the last pass completes it returns the result with a one-cycle done pulse.
// Optional feature macro: SHSEQ_FLAGS_EN (adds the zero and cout flag outputs).
// Ports:
//   clk     in   1       rising-edge clock
//   reset   in   1       synchronous, active-high reset
//   start   in   1       request strobe, sampled only while idle
//   op      in   2       00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amt     in   AMT_W   total shift amount
//   d_in    in   DATA_W  operand
//   busy    out  1       high while not idle
//   done    out  1       one-cycle pulse, result valid in this cycle
//   result  out  DATA_W  final value, held until overwritten by the next operation
//   zero    out  1       [SHSEQ_FLAGS_EN] result == 0
//   cout    out  1       [SHSEQ_FLAGS_EN] last bit shifted/rotated out
module shift_seq8 #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 3,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [AMT_W-1:0]  amt,
    input  logic [DATA_W-1:0] d_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
`ifdef SHSEQ_FLAGS_EN
    ,
    output logic              zero,
    output logic              cout
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(3);

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic [AMT_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;

    logic [STEP_W-1:0] w_step;
    logic [DATA_W-1:0] w_stage;
    logic              w_last;

    // Largest step that does not overshoot the remaining amount, so rem never underflows.
    assign w_step = (r_rem > MAX_STEP) ? 2'd3 : r_rem[STEP_W-1:0];
    assign w_last = (r_rem <= MAX_STEP);

    // Single 0..3-position stage: a 4:1 mux per bit, with fill chosen by op.
    always_comb begin
        w_stage = r_acc;
        case (r_op)
            OP_LSL: begin
                case (w_step)
                    2'd1:    w_stage = {r_acc[6:0], 1'b0};
                    2'd2:    w_stage = {r_acc[5:0], 2'b00};
                    2'd3:    w_stage = {r_acc[4:0], 3'b000};
                    default: w_stage = r_acc;
                endcase
            end
            OP_LSR: begin
                case (w_step)
                    2'd1:    w_stage = {1'b0, r_acc[7:1]};
                    2'd2:    w_stage = {2'b00, r_acc[7:2]};
                    2'd3:    w_stage = {3'b000, r_acc[7:3]};
                    default: w_stage = r_acc;
                endcase
            end
            OP_ASR: begin
                case (w_step)
                    2'd1:    w_stage = {r_acc[7], r_acc[7:1]};
                    2'd2:    w_stage = {{2{r_acc[7]}}, r_acc[7:2]};
                    2'd3:    w_stage = {{3{r_acc[7]}}, r_acc[7:3]};
                    default: w_stage = r_acc;
                endcase
            end
            default: begin
                case (w_step)
                    2'd1:    w_stage = {r_acc[0], r_acc[7:1]};
                    2'd2:    w_stage = {r_acc[1:0], r_acc[7:2]};
                    2'd3:    w_stage = {r_acc[2:0], r_acc[7:3]};
                    default: w_stage = r_acc;
                endcase
            end
        endcase
    end

`ifdef SHSEQ_FLAGS_EN
    logic w_cout;
    logic r_zero;
    logic r_cout;

    // Last bit to leave the stage on this pass; a zero-length step shifts nothing out.
    always_comb begin
        w_cout = 1'b0;
        if (w_step != 2'd0) begin
            case (r_op)
                OP_LSL:  w_cout = r_acc[4'd8 - {2'b00, w_step}];
                OP_LSR,
                OP_ASR:  w_cout = r_acc[{1'b0, w_step} - 3'd1];
                default: w_cout = w_stage[7];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_cout <= 1'b0;
        end else if (r_state == S_EXEC && w_last) begin
            r_zero <= (w_stage == '0);
            r_cout <= w_cout;
        end
    end

    assign zero = r_zero;
    assign cout = r_cout;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_rem    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= d_in;
                        r_rem   <= amt;
                        r_op    <= op;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_acc <= w_stage;
                    r_rem <= r_rem - {{(AMT_W-STEP_W){1'b0}}, w_step};
                    if (w_last) begin
                        r_result <= w_stage;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_shift_seq8.sv
// tb/tb_shift_seq8.sv - directed self-checking bench for shift_seq8
module tb_shift_seq8;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
`ifdef SHSEQ_FLAGS_EN
    logic       zero;
    logic       cout;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shift_seq8 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .d_in   (d_in),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef SHSEQ_FLAGS_EN
        ,
        .zero   (zero),
        .cout   (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge while idle; starts the op so it is accepted at the next edge,
    // then walks cycle by cycle to done. Optionally pokes start with other operands while busy.
    // Returns at the negedge of the first idle cycle after done.
    task automatic run(input string tag, input logic [1:0] o, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] exp_r, input int lat,
                       input logic exp_z, input logic exp_c, input bit poke);
        start = 1'b1; op = o; amt = a; d_in = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; amt = ~a; d_in = ~d;
        for (int c = 1; c < lat; c++) begin
            chk({tag, " busy exec"}, {7'd0, busy}, 8'd1);
            chk({tag, " done early"}, {7'd0, done}, 8'd0);
            start = poke;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " done"}, {7'd0, done}, 8'd1);
        chk({tag, " busy done"}, {7'd0, busy}, 8'd1);
        chk({tag, " result"}, result, exp_r);
`ifdef SHSEQ_FLAGS_EN
        chk({tag, " zero"}, {7'd0, zero}, {7'd0, exp_z});
        chk({tag, " cout"}, {7'd0, cout}, {7'd0, exp_c});
`else
        if (exp_z === 1'bx || exp_c === 1'bx) $display("[TB] unexpected x flag in %s", tag);
`endif
        @(negedge clk);
        chk({tag, " idle busy"}, {7'd0, busy}, 8'd0);
        chk({tag, " idle done"}, {7'd0, done}, 8'd0);
        chk({tag, " held result"}, result, exp_r);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; amt = 3'd0; d_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst done", {7'd0, done}, 8'd0);
        chk("rst result", result, 8'h00);
`ifdef SHSEQ_FLAGS_EN
        chk("rst zero", {7'd0, zero}, 8'd0);
        chk("rst cout", {7'd0, cout}, 8'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // name, op, amt, d_in, result, latency, zero, cout, poke start while busy
        run("lsl1",   2'b00, 3'd1, 8'h81, 8'h02, 2, 1'b0, 1'b1, 1'b0);
        run("asr7",   2'b10, 3'd7, 8'h80, 8'hFF, 4, 1'b0, 1'b0, 1'b1);
        run("lsr4",   2'b01, 3'd4, 8'hF0, 8'h0F, 3, 1'b0, 1'b0, 1'b0);
        run("ror3",   2'b11, 3'd3, 8'h96, 8'hD2, 2, 1'b0, 1'b1, 1'b1);
        run("lsl0",   2'b00, 3'd0, 8'h5A, 8'h5A, 2, 1'b0, 1'b0, 1'b0);
        run("ror0",   2'b11, 3'd0, 8'hC3, 8'hC3, 2, 1'b0, 1'b0, 1'b0);
        run("lsr1z",  2'b01, 3'd1, 8'h01, 8'h00, 2, 1'b1, 1'b1, 1'b0);
        run("lsl7",   2'b00, 3'd7, 8'hFF, 8'h80, 4, 1'b0, 1'b1, 1'b1);
        run("ror5",   2'b11, 3'd5, 8'h01, 8'h08, 3, 1'b0, 1'b0, 1'b1);
        run("asr6",   2'b10, 3'd6, 8'h40, 8'h01, 3, 1'b0, 1'b0, 1'b0);

        // Reset during the second EXEC cycle of an amt=7 operation.
        start = 1'b1; op = 2'b10; amt = 3'd7; d_in = 8'h80;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("mid busy1", {7'd0, busy}, 8'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid rst busy", {7'd0, busy}, 8'd0);
        chk("mid rst done", {7'd0, done}, 8'd0);
        chk("mid rst result", result, 8'h00);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mid no done", {7'd0, done}, 8'd0);
            chk("mid stay idle", {7'd0, busy}, 8'd0);
        end

        run("post rst", 2'b01, 3'd2, 8'hA4, 8'h29, 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
